// File: rtl/ioctl_sdram_pack.sv
// Packs the ioctl download byte stream into masked 16-bit little-endian words,
// queues them in a small FIFO and issues them on the SDRAM req/ack write port.
module ioctl_sdram_pack #(
    parameter int AW         = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_sdram,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic [AW:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    output logic [AW-1:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_dqm,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic          busy,
    output logic          overflow,
    output logic          dwnld_done,
    output logic [AW+1:0] byte_count
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    dqm;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   cnt;
    logic          dl_q, started;
    logic [AW-1:0] wa;
    logic [7:0]    lo, hi;
    logic          vlo, vhi;

    logic          rise, fall, cur_vlo, cur_vhi, push, pop, full, push_ok, drop, done_cond;
    logic [AW-1:0] w, n_wa;
    logic          b, n_vlo, n_vhi;
    logic [7:0]    n_lo, n_hi;
    entry_t        push_e;

    assign rise    = downloading & ~dl_q;
    assign fall    = ~downloading & dl_q;
    // a rising edge discards any stale partial before the same-cycle byte is considered
    assign cur_vlo = vlo & ~rise;
    assign cur_vhi = vhi & ~rise;
    assign w       = ioctl_addr[AW:1];
    assign b       = ioctl_addr[0];

    always_comb begin
        push        = 1'b0;
        push_e.addr = wa;
        push_e.din  = {cur_vhi ? hi : 8'h00, cur_vlo ? lo : 8'h00};
        push_e.dqm  = {~cur_vhi, ~cur_vlo};
        n_wa  = wa;
        n_lo  = lo;
        n_hi  = hi;
        n_vlo = cur_vlo;
        n_vhi = cur_vhi;
        if (fall) begin
            push  = vlo | vhi;
            n_vlo = 1'b0;
            n_vhi = 1'b0;
        end else if (ioctl_wr) begin
            if ((cur_vlo | cur_vhi) && w == wa && !(b ? cur_vhi : cur_vlo)) begin
                if (b) begin n_hi = ioctl_data; n_vhi = 1'b1; end
                else   begin n_lo = ioctl_data; n_vlo = 1'b1; end
                if (n_vlo && n_vhi) begin
                    push       = 1'b1;
                    push_e.din = {n_hi, n_lo};
                    push_e.dqm = 2'b00;
                    n_vlo      = 1'b0;
                    n_vhi      = 1'b0;
                end
            end else begin
                // displaced partial (if any) goes out masked; the new byte starts a fresh word
                push  = cur_vlo | cur_vhi;
                n_wa  = w;
                n_vlo = ~b;
                n_vhi = b;
                if (b) n_hi = ioctl_data;
                else   n_lo = ioctl_data;
            end
        end
    end

    assign pop       = sdram_ack & (cnt != '0);
    assign full      = cnt == (PW+1)'(FIFO_DEPTH);
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign done_cond = started & ~downloading & ~vlo & ~vhi & (cnt == '0);

    always_ff @(posedge clk_sdram or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            dl_q       <= 1'b0;
            started    <= 1'b0;
            wa         <= '0;
            lo         <= '0;
            hi         <= '0;
            vlo        <= 1'b0;
            vhi        <= 1'b0;
            overflow   <= 1'b0;
            dwnld_done <= 1'b0;
            byte_count <= '0;
        end else begin
            dl_q <= downloading;
            wa   <= n_wa;
            lo   <= n_lo;
            hi   <= n_hi;
            vlo  <= n_vlo;
            vhi  <= n_vhi;
            if (push_ok) begin
                mem[wptr] <= push_e;
                wptr      <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
            overflow   <= rise ? 1'b0 : (overflow | drop);
            byte_count <= rise ? (AW+2)'(ioctl_wr) : byte_count + (AW+2)'(ioctl_wr);
            started    <= rise ? 1'b1 : (done_cond ? 1'b0 : started);
            dwnld_done <= done_cond;
        end
    end

    assign sdram_req  = cnt != '0;
    assign sdram_addr = mem[rptr].addr;
    assign sdram_din  = mem[rptr].din;
    assign sdram_dqm  = mem[rptr].dqm;
    assign busy       = downloading | vlo | vhi | sdram_req;
endmodule

// File: tb/tb_ioctl_sdram_pack.sv
// Bench for ioctl_sdram_pack: directed scenarios plus a randomized stream
// checked cycle by cycle against a queue-based reference model.
module tb_ioctl_sdram_pack;
    localparam int AW = 22;
    localparam int DEPTH = 4;

    logic          clk_sdram = 1'b0;
    logic          rst_n, downloading, ioctl_wr, sdram_ack;
    logic [AW:0]   ioctl_addr;
    logic [7:0]    ioctl_data;
    logic [AW-1:0] sdram_addr;
    logic [15:0]   sdram_din;
    logic [1:0]    sdram_dqm;
    logic          sdram_req, busy, overflow, dwnld_done;
    logic [AW+1:0] byte_count;

    int total = 0;
    int bad = 0;

    ioctl_sdram_pack #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sdram(clk_sdram), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_dqm(sdram_dqm),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .busy(busy),
        .overflow(overflow), .dwnld_done(dwnld_done), .byte_count(byte_count)
    );

    always #5 clk_sdram = ~clk_sdram;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    m;
    } wrd_t;

    // reference model: pending byte lanes of one word, plus the queue of issued words
    bit            m_dl, m_ovf, m_started, m_done;
    bit            m_pv [2];
    logic [7:0]    m_pb [2];
    logic [AW-1:0] m_wa;
    logic [AW+1:0] m_bc;
    wrd_t          m_q[$];

    task automatic model_reset();
        m_dl = 0; m_ovf = 0; m_started = 0; m_done = 0;
        m_pv[0] = 0; m_pv[1] = 0; m_wa = '0; m_bc = '0;
        m_q.delete();
    endtask

    task automatic model_step(input bit dl, input bit wr, input logic [AW:0] a,
                              input logic [7:0] d, input bit ack);
        bit rise, fall, have, pop, full, dcond;
        wrd_t nw;
        logic [AW-1:0] w;
        int bl;
        rise  = dl && !m_dl;
        fall  = !dl && m_dl;
        dcond = m_started && !dl && !m_pv[0] && !m_pv[1] && m_q.size() == 0;
        pop   = ack && m_q.size() != 0;
        have  = 0;
        w  = a[AW:1];
        bl = int'(a[0]);
        nw.a = m_wa; nw.d = 16'h0; nw.m = 2'b11;
        if (rise) begin
            m_pv[0] = 0; m_pv[1] = 0; m_bc = '0; m_ovf = 0; m_started = 1;
        end
        if (fall) begin
            if (m_pv[0] || m_pv[1]) begin
                nw.a = m_wa;
                nw.d = {m_pv[1] ? m_pb[1] : 8'h00, m_pv[0] ? m_pb[0] : 8'h00};
                nw.m = {!m_pv[1], !m_pv[0]};
                have = 1;
            end
            m_pv[0] = 0; m_pv[1] = 0;
        end else if (wr) begin
            if ((m_pv[0] || m_pv[1]) && w == m_wa && !m_pv[bl]) begin
                m_pv[bl] = 1; m_pb[bl] = d;
                if (m_pv[0] && m_pv[1]) begin
                    nw.a = m_wa; nw.d = {m_pb[1], m_pb[0]}; nw.m = 2'b00; have = 1;
                    m_pv[0] = 0; m_pv[1] = 0;
                end
            end else begin
                if (m_pv[0] || m_pv[1]) begin
                    nw.a = m_wa;
                    nw.d = {m_pv[1] ? m_pb[1] : 8'h00, m_pv[0] ? m_pb[0] : 8'h00};
                    nw.m = {!m_pv[1], !m_pv[0]};
                    have = 1;
                end
                m_pv[0] = 0; m_pv[1] = 0;
                m_wa = w; m_pv[bl] = 1; m_pb[bl] = d;
            end
        end
        if (wr) m_bc = m_bc + 1'b1;
        full = m_q.size() == DEPTH;
        if (pop) void'(m_q.pop_front());
        if (have) begin
            if (full && !pop) m_ovf = 1;
            else m_q.push_back(nw);
        end
        if (dcond) m_started = 0;
        m_done = dcond;
        m_dl = dl;
    endtask

    // drive one cycle of inputs from a negedge, advance the model, return at the next negedge
    task automatic step(input bit dl, input bit wr, input logic [AW:0] a,
                        input logic [7:0] d, input bit ack);
        downloading = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_data = d; sdram_ack = ack;
        model_step(dl, wr, a, d, ack);
        @(posedge clk_sdram);
        @(negedge clk_sdram);
    endtask

    task automatic idle(input bit dl, input bit ack);
        step(dl, 0, '0, 8'h00, ack);
    endtask

    task automatic test_reset();
        rst_n = 0; downloading = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_data = '0; sdram_ack = 0;
        model_reset();
        #12;
        total++;
        if ({sdram_req, busy, overflow, dwnld_done, sdram_addr, sdram_din, sdram_dqm, byte_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b busy=%b ovf=%b done=%b addr=%h din=%h dqm=%b bc=%0d, want all 0",
                     sdram_req, busy, overflow, dwnld_done, sdram_addr, sdram_din, sdram_dqm, byte_count);
        end
        @(negedge clk_sdram);
        rst_n = 1;
        idle(0, 0);
        total++;
        if (sdram_req !== 1'b0 || dwnld_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: req=%b done=%b want 0 0", sdram_req, dwnld_done);
        end
    endtask

    task automatic test_basic();
        idle(1, 0);
        step(1, 1, 0, 8'h11, 0);
        step(1, 1, 1, 8'h22, 0);
        step(1, 1, 2, 8'h33, 0);
        step(1, 1, 3, 8'h44, 0);
        total++;
        if (sdram_req !== 1 || sdram_addr !== 0 || sdram_din !== 16'h2211 || sdram_dqm !== 2'b00) begin
            bad++;
            $display("FAIL basic_w0: req=%b addr=%h din=%h dqm=%b want 1 0 2211 00", sdram_req, sdram_addr, sdram_din, sdram_dqm);
        end
        idle(1, 1);
        total++;
        if (sdram_req !== 1 || sdram_addr !== 1 || sdram_din !== 16'h4433 || sdram_dqm !== 2'b00) begin
            bad++;
            $display("FAIL basic_w1: req=%b addr=%h din=%h dqm=%b want 1 1 4433 00", sdram_req, sdram_addr, sdram_din, sdram_dqm);
        end
        idle(1, 1);
        total++;
        if (sdram_req !== 0 || byte_count !== 4) begin
            bad++;
            $display("FAIL basic_count: req=%b bc=%0d want 0 4", sdram_req, byte_count);
        end
        idle(0, 0);
        total++;
        if (dwnld_done !== 1) begin
            bad++;
            $display("FAIL basic_done: done=%b want 1", dwnld_done);
        end
        idle(0, 0);
        total++;
        if (dwnld_done !== 0) begin
            bad++;
            $display("FAIL basic_done_pulse: done=%b want 0", dwnld_done);
        end
    endtask

    task automatic test_flush();
        int ndone = 0;
        idle(1, 0);
        step(1, 1, 0, 8'h11, 0);
        step(1, 1, 1, 8'h22, 0);
        step(1, 1, 2, 8'h33, 0);
        idle(1, 1);
        idle(0, 0);
        total++;
        if (sdram_req !== 1 || sdram_addr !== 1 || sdram_din !== 16'h0033 || sdram_dqm !== 2'b10) begin
            bad++;
            $display("FAIL flush_word: req=%b addr=%h din=%h dqm=%b want 1 1 0033 10", sdram_req, sdram_addr, sdram_din, sdram_dqm);
        end
        idle(0, 1);
        for (int i = 0; i < 5; i++) begin
            if (dwnld_done === 1'b1) ndone++;
            idle(0, 0);
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL flush_done_count: got %0d pulses want 1", ndone);
        end
    endtask

    task automatic test_odd_addr();
        idle(1, 0);
        step(1, 1, 5, 8'hA5, 0);
        step(1, 1, 8, 8'h5A, 0);
        total++;
        if (sdram_req !== 1 || sdram_addr !== 2 || sdram_din !== 16'hA500 || sdram_dqm !== 2'b01) begin
            bad++;
            $display("FAIL odd_hi: req=%b addr=%h din=%h dqm=%b want 1 2 a500 01", sdram_req, sdram_addr, sdram_din, sdram_dqm);
        end
        idle(1, 1);
        idle(0, 0);
        total++;
        if (sdram_req !== 1 || sdram_addr !== 4 || sdram_din !== 16'h005A || sdram_dqm !== 2'b10) begin
            bad++;
            $display("FAIL odd_lo: req=%b addr=%h din=%h dqm=%b want 1 4 005a 10", sdram_req, sdram_addr, sdram_din, sdram_dqm);
        end
        idle(0, 1);
        repeat (3) idle(0, 0);
    endtask

    task automatic test_overflow();
        int nw = 0;
        idle(1, 0);
        for (int i = 0; i < 12; i++) step(1, 1, (AW+1)'(i), 8'(i), 0);
        total++;
        if (overflow !== 1 || byte_count !== 12) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b bc=%0d want 1 12", overflow, byte_count);
        end
        for (int i = 0; i < 10; i++) begin
            if (sdram_req === 1'b1) nw++;
            idle(1, 1);
        end
        total++;
        if (nw != 4) begin
            bad++;
            $display("FAIL ovf_writes: got %0d writes want 4", nw);
        end
        idle(0, 0);
        idle(0, 0);
        idle(1, 0);
        total++;
        if (overflow !== 0 || byte_count !== 0) begin
            bad++;
            $display("FAIL ovf_clear: ovf=%b bc=%0d want 0 0", overflow, byte_count);
        end
        repeat (3) idle(0, 0);
    endtask

    task automatic test_full_ackpush();
        logic [7:0] lo, hi;
        idle(1, 0);
        for (int i = 0; i < 9; i++) step(1, 1, (AW+1)'(i), 8'(8'h40 + i), 0);
        step(1, 1, 9, 8'h49, 1);
        total++;
        if (overflow !== 0) begin
            bad++;
            $display("FAIL full_ackpush_ovf: ovf=%b want 0", overflow);
        end
        for (int k = 1; k <= 4; k++) begin
            lo = 8'(8'h40 + 2 * k);
            hi = 8'(8'h41 + 2 * k);
            total++;
            if (sdram_req !== 1 || sdram_addr !== AW'(k) || sdram_din !== {hi, lo} || sdram_dqm !== 2'b00) begin
                bad++;
                $display("FAIL full_ackpush_order%0d: req=%b addr=%h din=%h dqm=%b want 1 %h %h 00",
                         k, sdram_req, sdram_addr, sdram_din, sdram_dqm, k, {hi, lo});
            end
            idle(1, 1);
        end
        total++;
        if (sdram_req !== 0) begin
            bad++;
            $display("FAIL full_ackpush_empty: req=%b want 0", sdram_req);
        end
        repeat (3) idle(0, 0);
    endtask

    task automatic test_random();
        bit dl = 0, wr, ack;
        logic [AW:0] a = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) dl = !dl;
            wr  = dl && ($urandom_range(0, 1) == 1);
            ack = $urandom_range(0, 2) == 0;
            if (wr) a = ($urandom_range(0, 3) == 0) ? (AW+1)'($urandom_range(0, 63)) : a + 1'b1;
            step(dl, wr, a, 8'($urandom), ack);
            total++;
            if (sdram_req !== (m_q.size() != 0) || busy !== (m_dl || m_pv[0] || m_pv[1] || m_q.size() != 0)
                || overflow !== m_ovf || dwnld_done !== m_done || byte_count !== m_bc) begin
                bad++;
                $display("FAIL rand_status@%0d: req=%b busy=%b ovf=%b done=%b bc=%0d want %b %b %b %b %0d", c,
                         sdram_req, busy, overflow, dwnld_done, byte_count, m_q.size() != 0,
                         m_dl || m_pv[0] || m_pv[1] || m_q.size() != 0, m_ovf, m_done, m_bc);
            end
            if (m_q.size() != 0) begin
                total++;
                if (sdram_addr !== m_q[0].a || sdram_din !== m_q[0].d || sdram_dqm !== m_q[0].m) begin
                    bad++;
                    $display("FAIL rand_head@%0d: addr=%h din=%h dqm=%b want %h %h %b", c,
                             sdram_addr, sdram_din, sdram_dqm, m_q[0].a, m_q[0].d, m_q[0].m);
                end
            end
        end
        repeat (12) idle(0, 1);
        total++;
        if (sdram_req !== 0 || busy !== 0) begin
            bad++;
            $display("FAIL rand_drain: req=%b busy=%b want 0 0", sdram_req, busy);
        end
    endtask

    task automatic test_reset_mid();
        int bad_cycles = 0;
        idle(1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, (AW+1)'(i), 8'(i + 1), 0);
        downloading = 0;
        rst_n = 0;
        #2;
        model_reset();
        total++;
        if (sdram_req !== 0 || busy !== 0 || byte_count !== 0) begin
            bad++;
            $display("FAIL reset_mid: req=%b busy=%b bc=%0d want 0 0 0", sdram_req, busy, byte_count);
        end
        @(negedge clk_sdram);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            idle(0, 1);
            if (sdram_req !== 0 || dwnld_done !== 0) bad_cycles++;
        end
        total++;
        if (bad_cycles != 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: %0d cycles with req or done, want 0", bad_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_odd_addr();
        test_overflow();
        test_full_ackpush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
